// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline sequencer: stall vectors, FSM states,
// and small helpers used by pipe_ctrl and its watchdog.
package pipe_ctrl_pkg;

  localparam logic        NO_STOP   = 1'b0;
  localparam logic [31:0] ZERO_WORD = 32'h0000_0000;

  // Bit 0 = pc ... bit 5 = wb; a set bit holds that stage.
  localparam logic [5:0] STALL_NONE = 6'b000000;
  localparam logic [5:0] STALL_ID   = 6'b000111;
  localparam logic [5:0] STALL_EX   = 6'b001111;
  localparam logic [5:0] STALL_MEM  = 6'b011111;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_ACCEPT = 2'd1,
    ST_FLUSH  = 2'd2
  } state_e;

  function automatic logic [5:0] stall_arb(input logic id, input logic ex, input logic mem);
    logic [5:0] s;
    s = STALL_NONE;
    if (mem)     s = STALL_MEM;
    else if (ex) s = STALL_EX;
    else if (id) s = STALL_ID;
    return s;
  endfunction

  function automatic logic [31:0] align_vec(input logic [31:0] v);
    return {v[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/pipe_ctrl_wdog.sv
// Stall watchdog: counts consecutive stalled RUN cycles and pulses fire_o
// once the count reaches STALL_TIMEOUT-1 with the pipeline still stalled.
module pipe_ctrl_wdog
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned STALL_TIMEOUT = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic run_i,
  input  logic stall_pc_i,
  input  logic event_i,
  output logic fire_o
);

  localparam int CW = (STALL_TIMEOUT > 1) ? $clog2(STALL_TIMEOUT) : 1;
  localparam logic [CW-1:0] LAST = CW'(STALL_TIMEOUT - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          stalled;

  assign stalled = run_i && (stall_pc_i != NO_STOP);

  // A real trap or mret in the same cycle takes precedence and swallows the fire.
  assign fire_o = stalled && !event_i && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (!stalled || event_i || fire_o) cnt_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencer: stall arbitration plus trap/mret flush-and-redirect FSM.
// Optional stall watchdog is built when PIPE_CTRL_STALL_WDOG_EN is defined.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned FLUSH_CYCLES  = 1,
  parameter int unsigned STALL_TIMEOUT = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stallreq_id,
  input  logic        stallreq_ex,
  input  logic        stallreq_mem,
  input  logic        trap_req,
  input  logic        mret_req,
  input  logic [31:0] mtvec,
  input  logic [31:0] mepc,
  output logic [5:0]  stall,
  output logic        flush,
  output logic [31:0] new_pc,
  output logic        pc_redirect,
  output logic        busy,
  output logic        wdog_fire
);

  state_e      state_q;
  logic [2:0]  flush_cnt_q;
  logic        flush_q, redirect_q, busy_q;
  logic [31:0] new_pc_q;

  logic        in_run;
  logic [5:0]  stall_req;
  logic        wdog_fire_w;
  logic        accept;
  logic [31:0] target;

  assign in_run    = (state_q == ST_RUN) && !rst;
  assign stall_req = stall_arb(stallreq_id, stallreq_ex, stallreq_mem);

`ifdef PIPE_CTRL_STALL_WDOG_EN
  pipe_ctrl_wdog #(
    .STALL_TIMEOUT(STALL_TIMEOUT)
  ) u_wdog (
    .clk       (clk),
    .rst       (rst),
    .run_i     (in_run),
    .stall_pc_i(stall_req[0]),
    .event_i   (trap_req || mret_req),
    .fire_o    (wdog_fire_w)
  );
`else
  assign wdog_fire_w = 1'b0 & (STALL_TIMEOUT != 0);
`endif

  assign accept = in_run && (trap_req || mret_req || wdog_fire_w);
  assign target = (trap_req || !mret_req) ? align_vec(mtvec) : mepc;

  // Acceptance cycle freezes MEM and bubbles WB so the faulting op never commits.
  always_comb begin
    stall = STALL_NONE;
    if (accept)      stall = STALL_MEM;
    else if (in_run) stall = stall_req;
  end

  assign flush       = flush_q;
  assign pc_redirect = redirect_q;
  assign busy        = busy_q;
  assign new_pc      = new_pc_q;
  assign wdog_fire   = wdog_fire_w;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_RUN;
      flush_cnt_q <= 3'd0;
      flush_q     <= 1'b0;
      redirect_q  <= 1'b0;
      busy_q      <= 1'b0;
      new_pc_q    <= ZERO_WORD;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (accept) begin
            state_q     <= ST_ACCEPT;
            flush_cnt_q <= 3'd1;
            flush_q     <= 1'b1;
            redirect_q  <= 1'b1;
            busy_q      <= 1'b1;
            new_pc_q    <= target;
          end
        end
        ST_ACCEPT, ST_FLUSH: begin
          redirect_q <= 1'b0;
          // flush_cnt_q counts flush cycles already shown, ACCEPT included.
          if (flush_cnt_q >= 3'(FLUSH_CYCLES)) begin
            state_q     <= ST_RUN;
            flush_cnt_q <= 3'd0;
            flush_q     <= 1'b0;
            busy_q      <= 1'b0;
          end else begin
            state_q     <= ST_FLUSH;
            flush_cnt_q <= flush_cnt_q + 3'd1;
          end
        end
        default: state_q <= ST_RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: two instances (3-cycle and 1-cycle flush) checked every
// cycle against a countdown model, plus directed literal checks.
module tb_pipe_ctrl;

  localparam int FC_A = 3;
  localparam int FC_B = 1;
  localparam int TO   = 8;
`ifdef PIPE_CTRL_STALL_WDOG_EN
  localparam bit WD = 1'b1;
`else
  localparam bit WD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sid = 1'b0, sex = 1'b0, smem = 1'b0, trap = 1'b0, mret = 1'b0;
  logic [31:0] mtvec = 32'h0, mepc = 32'h0;

  logic [5:0]  a_stall, b_stall;
  logic        a_flush, b_flush, a_redir, b_redir, a_busy, b_busy, a_wdog, b_wdog;
  logic [31:0] a_npc, b_npc;

  pipe_ctrl #(.FLUSH_CYCLES(FC_A), .STALL_TIMEOUT(TO)) dut_a (
    .clk(clk), .rst(rst), .stallreq_id(sid), .stallreq_ex(sex), .stallreq_mem(smem),
    .trap_req(trap), .mret_req(mret), .mtvec(mtvec), .mepc(mepc),
    .stall(a_stall), .flush(a_flush), .new_pc(a_npc), .pc_redirect(a_redir),
    .busy(a_busy), .wdog_fire(a_wdog));

  pipe_ctrl #(.FLUSH_CYCLES(FC_B), .STALL_TIMEOUT(TO)) dut_b (
    .clk(clk), .rst(rst), .stallreq_id(sid), .stallreq_ex(sex), .stallreq_mem(smem),
    .trap_req(trap), .mret_req(mret), .mtvec(mtvec), .mepc(mepc),
    .stall(b_stall), .flush(b_flush), .new_pc(b_npc), .pc_redirect(b_redir),
    .busy(b_busy), .wdog_fire(b_wdog));

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model state: flush cycles left (0 = running), redirect flag, last target, stall run length.
  int          rem[2] = '{0, 0};
  bit          first[2] = '{1'b0, 1'b0};
  logic [31:0] lpc[2] = '{32'h0, 32'h0};
  int          wd[2] = '{0, 0};

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic model_cycle(input int i, input int fc, input string tag,
                             input logic [5:0] st, input logic fl, input logic [31:0] npc,
                             input logic rd, input logic by, input logic wf);
    logic [5:0] e_st;
    bit e_wf, ev, stalled;
    e_st = 6'h00; e_wf = 1'b0; ev = 1'b0; stalled = 1'b0;
    if (!rst && rem[i] == 0) begin
      stalled = sid | sex | smem;
      e_wf = WD && stalled && !trap && !mret && (wd[i] == TO - 1);
      ev = trap | mret | e_wf;
      if (ev || smem) e_st = 6'h1f;
      else if (sex)   e_st = 6'h0f;
      else if (sid)   e_st = 6'h07;
    end
    chk({tag, ".stall"},  32'(st), 32'(e_st));
    chk({tag, ".flush"},  32'(fl), 32'(rem[i] > 0));
    chk({tag, ".busy"},   32'(by), 32'(rem[i] > 0));
    chk({tag, ".redir"},  32'(rd), 32'(first[i]));
    chk({tag, ".new_pc"}, npc, lpc[i]);
    chk({tag, ".wdog"},   32'(wf), 32'(e_wf));
    if (rst) begin
      rem[i] = 0; first[i] = 1'b0; lpc[i] = 32'h0; wd[i] = 0;
    end else if (rem[i] == 0) begin
      if (ev) begin
        rem[i] = fc; first[i] = 1'b1; wd[i] = 0;
        lpc[i] = (mret && !trap) ? mepc : {mtvec[31:2], 2'b00};
      end else begin
        wd[i] = stalled ? wd[i] + 1 : 0;
      end
    end else begin
      rem[i] = rem[i] - 1; first[i] = 1'b0; wd[i] = 0;
    end
  endtask

  always @(negedge clk) begin
    model_cycle(0, FC_A, "A", a_stall, a_flush, a_npc, a_redir, a_busy, a_wdog);
    model_cycle(1, FC_B, "B", b_stall, b_flush, b_npc, b_redir, b_busy, b_wdog);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    sid = 1'b0; sex = 1'b0; smem = 1'b0; trap = 1'b0; mret = 1'b0;
  endtask

  initial begin
    int nf, nr, nb, nw;
    bit heavy;
    step(); step();
    rst = 1'b0;
    #1;
    chk("rst_stall", 32'(a_stall), 32'h0);
    chk("rst_flush", 32'(a_flush), 32'h0);
    chk("rst_npc",   a_npc, 32'h0);
    chk("rst_busy",  32'(b_busy), 32'h0);
    chk("rst_redir", 32'(b_redir), 32'h0);
    step();

    // ID + MEM stall: MEM wins.
    sid = 1'b1; smem = 1'b1;
    repeat (3) begin
      #1;
      chk("idmem_stall", 32'(a_stall), 32'h1f);
      chk("idmem_flush", 32'(a_flush), 32'h0);
      chk("idmem_busy",  32'(b_busy), 32'h0);
      step();
    end
    idle(); step();

    // Trap with unaligned mtvec.
    mtvec = 32'h0000_0103; trap = 1'b1;
    #1;
    chk("trap_acc_stall", 32'(b_stall), 32'h1f);
    step(); trap = 1'b0; #1;
    chk("trap_b_flush", 32'(b_flush), 32'h1);
    chk("trap_b_redir", 32'(b_redir), 32'h1);
    chk("trap_b_npc",   b_npc, 32'h0000_0100);
    step(); #1;
    chk("trap_b_flush_off", 32'(b_flush), 32'h0);
    chk("trap_a_redir_off", 32'(a_redir), 32'h0);
    chk("trap_a_flush2",    32'(a_flush), 32'h1);
    step(); #1;
    chk("trap_a_flush3", 32'(a_flush), 32'h1);
    step(); #1;
    chk("trap_a_flush_off", 32'(a_flush), 32'h0);
    step();

    // mret with a 3-cycle flush.
    mepc = 32'h0000_2040; mret = 1'b1;
    step(); mret = 1'b0;
    nf = 0; nr = 0; nb = 0;
    repeat (6) begin
      #1;
      nf += int'(a_flush); nr += int'(a_redir); nb += int'(a_busy);
      step();
    end
    chk("mret_flush_cycles", 32'(nf), 32'd3);
    chk("mret_redir_cycles", 32'(nr), 32'd1);
    chk("mret_busy_cycles",  32'(nb), 32'd3);
    chk("mret_npc", a_npc, 32'h0000_2040);

    // Trap beats mret; trap raised inside FLUSH is ignored.
    mtvec = 32'h100; mepc = 32'h200; trap = 1'b1; mret = 1'b1;
    step(); idle(); #1;
    chk("prio_npc_a", a_npc, 32'h100);
    chk("prio_npc_b", b_npc, 32'h100);
    step(); trap = 1'b1; mtvec = 32'h500;
    step(); trap = 1'b0;
    nr = 0;
    repeat (4) begin
      #1; nr += int'(a_redir); step();
    end
    chk("flush_ignore_redir", 32'(nr), 32'd0);
    chk("flush_ignore_npc", a_npc, 32'h100);

    // Reset in the middle of a flush, then a normal trap.
    mtvec = 32'h300; trap = 1'b1;
    step(); trap = 1'b0;
    step(); rst = 1'b1;
    step(); rst = 1'b0; #1;
    chk("midrst_flush", 32'(a_flush), 32'h0);
    chk("midrst_busy",  32'(a_busy), 32'h0);
    chk("midrst_npc",   a_npc, 32'h0);
    mtvec = 32'h400; trap = 1'b1;
    step(); trap = 1'b0; #1;
    chk("postrst_redir", 32'(a_redir), 32'h1);
    chk("postrst_npc",   a_npc, 32'h400);
    repeat (4) step();

    // Watchdog: fires on the 8th stalled cycle when built in.
    mtvec = 32'h600; sex = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      #1;
      chk($sformatf("wdog_fire_c%0d", k), 32'(a_wdog), 32'(WD && k == 8));
      chk($sformatf("wdog_stall_c%0d", k), 32'(a_stall), (WD && k == 8) ? 32'h1f : 32'h0f);
      step();
    end
    sex = 1'b0; #1;
    chk("wdog_redir", 32'(a_redir), 32'(WD));
    repeat (4) step();
    nw = 0;
    sex = 1'b1;
    repeat (7) begin #1; nw += int'(a_wdog); step(); end
    sex = 1'b0; step();
    sex = 1'b1;
    repeat (7) begin #1; nw += int'(a_wdog); step(); end
    chk("wdog_drop_nofire", 32'(nw), 32'd0);
    idle(); repeat (4) step();

    // Randomised phase; bursts of long EX stalls exercise the watchdog.
    heavy = 1'b0;
    for (int c = 0; c < 4000; c++) begin
      if (c % 16 == 0) heavy = ($urandom_range(0, 3) == 0);
      if (heavy) begin
        sex  = ($urandom_range(0, 19) != 0);
        sid  = ($urandom_range(0, 3) == 0);
        smem = 1'b0;
        trap = ($urandom_range(0, 99) == 0);
        mret = 1'b0;
        rst  = 1'b0;
      end else begin
        sid  = ($urandom_range(0, 3) == 0);
        sex  = ($urandom_range(0, 3) == 0);
        smem = ($urandom_range(0, 3) == 0);
        trap = ($urandom_range(0, 15) == 0);
        mret = ($urandom_range(0, 19) == 0);
        rst  = ($urandom_range(0, 99) == 0);
      end
      mtvec = $urandom;
      mepc  = $urandom;
      step();
    end
    idle(); rst = 1'b0;
    step(); step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
Central pipeline sequencer for the RV32I core. It does three things:
- Arbitrates stall requests from ID, EX and MEM into the 6-bit stall vector consumed by pc_reg and all pipeline registers (if_id … mem_wb).
- Sequences trap entry and mret return through a small FSM that drives the global flush and the PC redirect.
- Optionally runs a stall watchdog.

It sits beside the datapath, fed by stage stall requests and the CSR unit.

Parameters:
FLUSH_CYCLES, 1, number of consecutive cycles flush is held high (1..7).
STALL_TIMEOUT, 1024, consecutive stalled cycles before the watchdog fires (watchdog build only).

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
stallreq_id  in  1  ID stage stall request (load-use hazard)
stallreq_ex  in  1  EX stage stall request (multi-cycle op)
stallreq_mem  in  1  MEM stage stall request (bus wait)
trap_req  in  1  exception raised by the instruction in MEM
mret_req  in  1  mret committing in MEM
mtvec  in  32  trap vector CSR
mepc  in  32  exception PC CSR
stall  out  6  [0]=pc,[1]=if_id,[2]=id_ex,[3]=ex_mem,[4]=mem_wb,[5]=wb; 1=Stop
flush  out  1  global pipeline flush
new_pc  out  32  redirect target, valid when pc_redirect=1
pc_redirect  out  1  one-cycle PC load pulse
busy  out  1  FSM not in RUN
wdog_fire  out  1  watchdog pulse (0 when feature absent)

Behaviour:
- Reset values: stall=0, flush=0, new_pc=0, pc_redirect=0, busy=0, wdog_fire=0, state=RUN, flush counter=0, watchdog counter=0.
- States: RUN, ACCEPT, FLUSH.
- RUN, stall arbitration (combinational), highest priority first:
  - stallreq_mem → 6'b011111
  - stallreq_ex → 6'b001111
  - stallreq_id → 6'b000111
  - otherwise → 6'b000000
- RUN, event acceptance: trap_req, mret_req or a watchdog fire moves the FSM to ACCEPT on the next edge.
  - Target is latched at that edge: trap or watchdog → {mtvec[31:2],2'b00}; mret → mepc.
  - If trap_req and mret_req are both high, trap wins.
  - An event has priority over any stall request raised in the same cycle.
  - In the acceptance cycle, stall=6'b011111. This holds the faulting instruction in MEM and bubbles WB, so it never commits.
- ACCEPT (exactly 1 cycle):
  - stall=0, flush=1, pc_redirect=1, new_pc=latched target, busy=1.
  - Next state: FLUSH if FLUSH_CYCLES>1, else RUN.
- FLUSH:
  - flush=1, stall=0, busy=1, pc_redirect=0.
  - Counts until flush has been high FLUSH_CYCLES cycles in total (including ACCEPT), then goes to RUN.
- new_pc retains the last target outside redirect cycles.
- In ACCEPT and FLUSH, trap_req, mret_req and all stallreq_* are ignored (they belong to flushed instructions).
- After returning to RUN, requests are honoured the same cycle. Back-to-back traps are legal.
- Total redirect latency from trap_req seen high in RUN to pc_redirect high: 1 cycle.
- rst high in any state returns the FSM to RUN with all outputs at reset values on the next edge. An in-flight flush is abandoned.

Optional Feature:
Macro PIPE_CTRL_STALL_WDOG_EN.
- With the macro:
  - A counter increments each RUN cycle with stall[0]=1 and clears on any RUN cycle with stall[0]=0, and on leaving RUN.
  - When the counter reaches STALL_TIMEOUT-1 while still stalled, wdog_fire pulses high for 1 cycle and the counter clears.
  - A fire is treated exactly as a trap (target mtvec). It loses to a simultaneous trap_req or mret_req, in which case no pulse is emitted.
- Without the macro: no counter is instantiated and wdog_fire is constant 0.

Decomposition:
- Shared definitions (define.v): Stop/NoStop, stall vector constants STALL_NONE/STALL_ID/STALL_EX/STALL_MEM, FSM state encodings, ZeroWord.
- One natural sub-module: pipe_ctrl_wdog (counter + fire pulse), instantiated only under PIPE_CTRL_STALL_WDOG_EN.

Test Plan:
1. stallreq_id=1 and stallreq_mem=1 together for 3 cycles → stall=6'b011111 for those 3 cycles, flush=0, busy=0.
2. mtvec=0x0000_0103, trap_req=1 for one cycle → that cycle stall=6'b011111; next cycle flush=1, pc_redirect=1, new_pc=0x0000_0100; following cycle flush=0 (FLUSH_CYCLES=1).
3. FLUSH_CYCLES=3, mret_req=1, mepc=0x0000_2040 → flush high exactly 3 cycles, pc_redirect only in the first, new_pc=0x0000_2040, busy high 3 cycles.
4. trap_req and mret_req both high, mtvec=0x100, mepc=0x200 → new_pc=0x100. A trap_req asserted during FLUSH → ignored, no second redirect.
5. rst=1 in the second cycle of a FLUSH_CYCLES=3 flush → next cycle all outputs 0, state RUN; a subsequent trap is handled normally.
6. With PIPE_CTRL_STALL_WDOG_EN and STALL_TIMEOUT=8, stallreq_ex held high → wdog_fire pulses on the 8th stalled cycle, then the redirect goes to mtvec. Dropping the stall at cycle 7 → no fire.
